// File: rtl/sc_score_pkg.sv
// Shared types and constants for the score-update arbiter and its helpers.
package sc_score_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBurst = 2'd1,
        StClear = 2'd2,
        StHalt  = 2'd3
    } arb_state_e;

    localparam logic [7:0]  ScoreEnd           = 8'd100;
    localparam int unsigned BonusPointsDefault = 5;
    localparam int unsigned HaltCyclesDefault  = 255;

endpackage

// File: rtl/sc_score_pending_counter.sv
// Saturating up/down counter holding ticks that arrived while the strobe was busy.
module sc_score_pending_counter #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    input  logic             flush,
    output logic [WIDTH-1:0] count,
    output logic             full
);

    localparam logic [WIDTH-1:0] CountMax = '1;
    localparam logic [WIDTH-1:0] CountOne = WIDTH'(1);

    assign full = (count == CountMax);

    // inc and dec together cancel; an inc at full is refused and reported by the caller.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (inc && !dec && !full) begin
            count <= count + CountOne;
        end else if (dec && !inc && (count != '0)) begin
            count <= count - CountOne;
        end
    end

endmodule

// File: rtl/sc_score_arbiter.sv
// Sole driver of the score counter's COUNT/CLEARCOUNT strobes: ticks, bonus bursts, clears.
// Optional HALT auto-clear timer is enabled by defining SC_SCORE_ARB_AUTOCLEAR_EN.
module sc_score_arbiter
    import sc_score_pkg::*;
#(
    parameter int unsigned BONUS_POINTS = BonusPointsDefault,
    parameter int unsigned PEND_W       = 3,
    parameter int unsigned HALT_CYCLES  = HaltCyclesDefault
) (
    input  logic SC_COUNTER_SCORE_CLOCK,
    input  logic SC_COUNTER_SCORE_RESET_InLow,
    input  logic SC_SCORE_ARB_TICK_InLow,
    input  logic SC_SCORE_ARB_BONUS_InLow,
    input  logic SC_SCORE_ARB_CLEAR_InLow,
    input  logic SC_SCORE_ARB_ENDCOUNT_InLow,
    output logic SC_SCORE_ARB_COUNT_OutLow,
    output logic SC_SCORE_ARB_CLEARCOUNT_OutLow,
    output logic SC_SCORE_ARB_BUSY,
    output logic SC_SCORE_ARB_GAMEOVER,
    output logic SC_SCORE_ARB_DROP
);

    if (BONUS_POINTS < 1 || BONUS_POINTS > 15) begin : g_bad_bonus
        $error("BONUS_POINTS must be in 1..15");
    end
    if (PEND_W < 1) begin : g_bad_pend
        $error("PEND_W must be at least 1");
    end
    if (HALT_CYCLES < 1 || HALT_CYCLES > 255) begin : g_bad_halt
        $error("HALT_CYCLES must be in 1..255");
    end

    localparam logic [3:0] BonusLoad = 4'(BONUS_POINTS);

    logic clk;
    logic rst_n;

    arb_state_e        state;
    logic [3:0]        remaining;
    logic              bonus_flag;
    logic              count_reg;
    logic              clear_reg;
    logic              gameover;
    logic              drop;

    logic [PEND_W-1:0] pending;
    logic              pend_full;
    logic              pend_nonzero;
    logic              pend_inc;
    logic              pend_dec;
    logic              pend_flush;

    logic tick;
    logic bonus;
    logic clr;
    logic at_end;
    logic burst_last;
    logic decide;
    logic burst_mid;
    logic take_bonus;
    logic serve;
    logic halt_go;
    logic auto_clr;
    logic tick_drop;
    logic bonus_drop;

    assign clk    = SC_COUNTER_SCORE_CLOCK;
    assign rst_n  = SC_COUNTER_SCORE_RESET_InLow;
    assign tick   = ~SC_SCORE_ARB_TICK_InLow;
    assign bonus  = ~SC_SCORE_ARB_BONUS_InLow;
    assign clr    = ~SC_SCORE_ARB_CLEAR_InLow;
    assign at_end = ~SC_SCORE_ARB_ENDCOUNT_InLow;

    assign pend_nonzero = (pending != '0);
    assign burst_last   = (remaining <= 4'd1);

    // The last burst edge makes the idle decision itself so queued work follows with no gap.
    // CLEAR ignores end-of-count because the counter only drops to zero at the closing edge.
    always_comb begin
        decide    = 1'b0;
        burst_mid = 1'b0;
        halt_go   = 1'b0;
        if (!clr && !auto_clr) begin
            unique case (state)
                StIdle: begin
                    halt_go = at_end;
                    decide  = !at_end;
                end
                StBurst: begin
                    halt_go   = at_end;
                    decide    = !at_end && burst_last;
                    burst_mid = !at_end && !burst_last;
                end
                StClear: decide = 1'b1;
                StHalt:  ;
                default: ;
            endcase
        end
    end

    assign take_bonus = decide && (bonus || bonus_flag);
    assign serve      = decide && !take_bonus && (tick || pend_nonzero);
    assign pend_inc   = (decide || burst_mid) && tick;
    assign pend_dec   = serve;
    assign pend_flush = clr || auto_clr;
    assign tick_drop  = pend_inc && pend_full && !pend_dec;
    assign bonus_drop = burst_mid && bonus && bonus_flag;

    sc_score_pending_counter #(
        .WIDTH (PEND_W)
    ) u_pending (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pend_inc),
        .dec   (pend_dec),
        .flush (pend_flush),
        .count (pending),
        .full  (pend_full)
    );

`ifdef SC_SCORE_ARB_AUTOCLEAR_EN
    logic [7:0] halt_timer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_timer <= '0;
        end else if (state == StHalt && !clr && !auto_clr) begin
            halt_timer <= halt_timer + 8'd1;
        end else begin
            halt_timer <= '0;
        end
    end

    // Fires on the edge closing the HALT_CYCLES-th cycle spent in HALT.
    assign auto_clr = (state == StHalt) && (({1'b0, halt_timer} + 9'd1) >= 9'(HALT_CYCLES));
`else
    assign auto_clr = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            remaining  <= '0;
            bonus_flag <= 1'b0;
            count_reg  <= 1'b1;
            clear_reg  <= 1'b1;
            gameover   <= 1'b0;
            drop       <= 1'b0;
        end else begin
            count_reg <= ~(take_bonus | serve | burst_mid);
            clear_reg <= ~(clr | auto_clr);
            drop      <= tick_drop | bonus_drop;
            if (clr || auto_clr) begin
                state      <= StClear;
                bonus_flag <= 1'b0;
                gameover   <= 1'b0;
            end else if (halt_go) begin
                state    <= StHalt;
                gameover <= 1'b1;
            end else if (take_bonus) begin
                state      <= StBurst;
                remaining  <= BonusLoad;
                // A fresh bonus arriving while the flagged one is launched stays queued.
                bonus_flag <= bonus & bonus_flag;
            end else if (decide) begin
                state <= StIdle;
            end else if (burst_mid) begin
                remaining <= remaining - 4'd1;
                if (bonus) begin
                    bonus_flag <= 1'b1;
                end
            end
        end
    end

    // End-of-count gating is combinational so the counter cannot step past its end value.
    assign SC_SCORE_ARB_COUNT_OutLow      = count_reg | at_end;
    assign SC_SCORE_ARB_CLEARCOUNT_OutLow = clear_reg;
    assign SC_SCORE_ARB_BUSY              = (state != StIdle) | pend_nonzero | bonus_flag;
    assign SC_SCORE_ARB_GAMEOVER          = gameover;
    assign SC_SCORE_ARB_DROP              = drop;

endmodule

// File: tb/tb_sc_score_arbiter.sv
// Directed bench for sc_score_arbiter with a behavioural score counter attached to its strobes.
module tb_sc_score_arbiter;
    import sc_score_pkg::*;

    localparam int unsigned BONUS = 5;
    localparam int unsigned PEND  = 3;
    localparam int unsigned HALT  = 10;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic tick_n  = 1'b1;
    logic bonus_n = 1'b1;
    logic clear_n = 1'b1;
    logic endcount_n;
    logic count_n;
    logic clearcount_n;
    logic busy;
    logic gameover;
    logic drop;
    logic [7:0] score;

    int vectors     = 0;
    int miscompares = 0;
    int run         = 0;
    int last_run    = 0;
    int low_cnt     = 0;
    int drop_cnt    = 0;

    always #5 clk = ~clk;

    sc_score_arbiter #(
        .BONUS_POINTS (BONUS),
        .PEND_W       (PEND),
        .HALT_CYCLES  (HALT)
    ) dut (
        .SC_COUNTER_SCORE_CLOCK         (clk),
        .SC_COUNTER_SCORE_RESET_InLow   (rst_n),
        .SC_SCORE_ARB_TICK_InLow        (tick_n),
        .SC_SCORE_ARB_BONUS_InLow       (bonus_n),
        .SC_SCORE_ARB_CLEAR_InLow       (clear_n),
        .SC_SCORE_ARB_ENDCOUNT_InLow    (endcount_n),
        .SC_SCORE_ARB_COUNT_OutLow      (count_n),
        .SC_SCORE_ARB_CLEARCOUNT_OutLow (clearcount_n),
        .SC_SCORE_ARB_BUSY              (busy),
        .SC_SCORE_ARB_GAMEOVER          (gameover),
        .SC_SCORE_ARB_DROP              (drop)
    );

    // Score counter: COUNT has priority over CLEARCOUNT, shares the system reset.
    assign endcount_n = (score != ScoreEnd);
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) score <= 8'd0;
        else if (!count_n) score <= score + 8'd1;
        else if (!clearcount_n) score <= 8'd0;
    end

    always @(negedge clk) begin
        if (!count_n) begin
            run = run + 1;
            low_cnt = low_cnt + 1;
        end else begin
            if (run != 0) last_run = run;
            run = 0;
        end
        if (drop) drop_cnt = drop_cnt + 1;
    end

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (count_n !== 1'b1) begin miscompares++; $display("FAIL reset_count: got %b want 1", count_n); end
        vectors++; if (clearcount_n !== 1'b1) begin miscompares++; $display("FAIL reset_clearcount: got %b want 1", clearcount_n); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (gameover !== 1'b0) begin miscompares++; $display("FAIL reset_gameover: got %b want 0", gameover); end
        vectors++; if (drop !== 1'b0) begin miscompares++; $display("FAIL reset_drop: got %b want 0", drop); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_tick();
        int s0;
        s0 = int'(score);
        @(negedge clk); tick_n = 1'b0;
        @(negedge clk);
        vectors++; if (count_n !== 1'b0) begin miscompares++; $display("FAIL tick_latency: got %b want 0", count_n); end
        tick_n = 1'b1;
        @(negedge clk);
        vectors++; if (count_n !== 1'b1) begin miscompares++; $display("FAIL tick_width: got %b want 1", count_n); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL tick_busy: got %b want 0", busy); end
        vectors++; if (int'(score) !== s0 + 1) begin miscompares++; $display("FAIL tick_score: got %0d want %0d", score, s0 + 1); end
    endtask

    task automatic test_bonus_with_ticks();
        int s0;
        s0 = int'(score);
        last_run = 0;
        @(negedge clk); bonus_n = 1'b0;
        @(negedge clk); bonus_n = 1'b1; tick_n = 1'b0;
        vectors++; if (count_n !== 1'b0) begin miscompares++; $display("FAIL bonus_latency: got %b want 0", count_n); end
        @(negedge clk); tick_n = 1'b1;
        @(negedge clk); tick_n = 1'b0;
        @(negedge clk); tick_n = 1'b1;
        repeat (10) @(negedge clk);
        vectors++; if (last_run !== 7) begin miscompares++; $display("FAIL bonus_run: got %0d want 7", last_run); end
        vectors++; if (int'(score) !== s0 + 7) begin miscompares++; $display("FAIL bonus_score: got %0d want %0d", score, s0 + 7); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL bonus_busy: got %b want 0", busy); end
    endtask

    task automatic test_saturation();
        int s0;
        int d0;
        s0 = int'(score);
        d0 = drop_cnt;
        last_run = 0;
        @(negedge clk); bonus_n = 1'b0;
        @(negedge clk); bonus_n = 1'b1; tick_n = 1'b0;
        @(negedge clk); bonus_n = 1'b0;
        @(negedge clk); bonus_n = 1'b1;
        repeat (7) @(negedge clk);
        tick_n = 1'b1;
        repeat (15) @(negedge clk);
        vectors++; if (last_run !== 17) begin miscompares++; $display("FAIL sat_run: got %0d want 17", last_run); end
        vectors++; if (int'(score) !== s0 + 17) begin miscompares++; $display("FAIL sat_score: got %0d want %0d", score, s0 + 17); end
        vectors++; if (drop_cnt - d0 !== 2) begin miscompares++; $display("FAIL sat_drops: got %0d want 2", drop_cnt - d0); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL sat_busy: got %b want 0", busy); end
    endtask

    task automatic test_clear_mid_burst();
        int d0;
        d0 = drop_cnt;
        @(negedge clk); bonus_n = 1'b0;
        @(negedge clk); bonus_n = 1'b1; tick_n = 1'b0;
        @(negedge clk); tick_n = 1'b1;
        @(negedge clk); tick_n = 1'b0; clear_n = 1'b0;
        @(negedge clk);
        vectors++; if (clearcount_n !== 1'b0) begin miscompares++; $display("FAIL clr_strobe: got %b want 0", clearcount_n); end
        vectors++; if (count_n !== 1'b1) begin miscompares++; $display("FAIL clr_count_overlap: got %b want 1", count_n); end
        tick_n = 1'b1; clear_n = 1'b1;
        @(negedge clk);
        vectors++; if (clearcount_n !== 1'b1) begin miscompares++; $display("FAIL clr_width: got %b want 1", clearcount_n); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL clr_busy: got %b want 0", busy); end
        vectors++; if (score !== 8'd0) begin miscompares++; $display("FAIL clr_score: got %0d want 0", score); end
        repeat (5) @(negedge clk);
        vectors++; if (score !== 8'd0) begin miscompares++; $display("FAIL clr_flushed: got %0d want 0", score); end
        vectors++; if (drop_cnt !== d0) begin miscompares++; $display("FAIL clr_nodrop: got %0d want %0d", drop_cnt, d0); end
    endtask

    task automatic test_gameover();
        int lc0;
        int d0;
        @(negedge clk); tick_n = 1'b0;
        repeat (99) @(negedge clk);
        tick_n = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (score !== 8'd99) begin miscompares++; $display("FAIL go_preload: got %0d want 99", score); end
        @(negedge clk); bonus_n = 1'b0;
        @(negedge clk); bonus_n = 1'b1;
        vectors++; if (count_n !== 1'b0) begin miscompares++; $display("FAIL go_last_strobe: got %b want 0", count_n); end
        @(negedge clk);
        vectors++; if (count_n !== 1'b1) begin miscompares++; $display("FAIL go_guard: got %b want 1", count_n); end
        vectors++; if (score !== 8'd100) begin miscompares++; $display("FAIL go_score100: got %0d want 100", score); end
        @(negedge clk);
        vectors++; if (gameover !== 1'b1) begin miscompares++; $display("FAIL go_flag: got %b want 1", gameover); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL go_busy: got %b want 1", busy); end
        lc0 = low_cnt;
        d0 = drop_cnt;
        tick_n = 1'b0;
        @(negedge clk); tick_n = 1'b1; bonus_n = 1'b0;
        @(negedge clk); bonus_n = 1'b1;
        @(negedge clk);
        vectors++; if (score !== 8'd100) begin miscompares++; $display("FAIL go_frozen: got %0d want 100", score); end
        vectors++; if (low_cnt !== lc0) begin miscompares++; $display("FAIL go_count_high: got %0d lows want 0", low_cnt - lc0); end
        vectors++; if (drop_cnt !== d0) begin miscompares++; $display("FAIL go_nodrop: got %0d want %0d", drop_cnt, d0); end
        vectors++; if (gameover !== 1'b1) begin miscompares++; $display("FAIL go_hold: got %b want 1", gameover); end
    endtask

    // Continues directly from test_gameover: four HALT cycles have already been observed.
    task automatic test_autoclear();
        int n;
        bit seen;
        n = 4;
        seen = 1'b0;
        while (n < 40 && !seen) begin
            @(negedge clk);
            n++;
            if (clearcount_n == 1'b0) seen = 1'b1;
        end
`ifdef SC_SCORE_ARB_AUTOCLEAR_EN
        vectors++; if (seen !== 1'b1) begin miscompares++; $display("FAIL ac_fired: got %b want 1", seen); end
        vectors++; if (n !== HALT + 1) begin miscompares++; $display("FAIL ac_delay: got %0d want %0d", n, HALT + 1); end
        vectors++; if (gameover !== 1'b0) begin miscompares++; $display("FAIL ac_gameover: got %b want 0", gameover); end
        @(negedge clk);
`else
        vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL halt_persist: got %b want 0", seen); end
        vectors++; if (gameover !== 1'b1) begin miscompares++; $display("FAIL halt_gameover: got %b want 1", gameover); end
        clear_n = 1'b0;
        @(negedge clk);
        vectors++; if (clearcount_n !== 1'b0) begin miscompares++; $display("FAIL halt_clear: got %b want 0", clearcount_n); end
        vectors++; if (gameover !== 1'b0) begin miscompares++; $display("FAIL halt_clear_go: got %b want 0", gameover); end
        clear_n = 1'b1;
        @(negedge clk);
`endif
        vectors++; if (clearcount_n !== 1'b1) begin miscompares++; $display("FAIL exit_clear_width: got %b want 1", clearcount_n); end
        vectors++; if (score !== 8'd0) begin miscompares++; $display("FAIL exit_score: got %0d want 0", score); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL exit_busy: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clk); bonus_n = 1'b0;
        @(negedge clk); bonus_n = 1'b1;
        @(negedge clk);
        vectors++; if (count_n !== 1'b0) begin miscompares++; $display("FAIL rstb_running: got %b want 0", count_n); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (count_n !== 1'b1) begin miscompares++; $display("FAIL rstb_count: got %b want 1", count_n); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstb_busy: got %b want 0", busy); end
        vectors++; if (clearcount_n !== 1'b1) begin miscompares++; $display("FAIL rstb_clearcount: got %b want 1", clearcount_n); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        vectors++; if (count_n !== 1'b1) begin miscompares++; $display("FAIL rstb_after: got %b want 1", count_n); end
    endtask

    initial begin
        test_reset();
        test_single_tick();
        test_bonus_with_ticks();
        test_saturation();
        test_clear_mid_burst();
        test_gameover();
        test_autoclear();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
